// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = '1;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_e;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Byte-wide register port between the I2C target and the host register file.
interface i2c_target_regs_if;
  import i2c_pkg::*;

  logic              wr_valid;
  logic [BYTE_W-1:0] wr_addr;
  logic [BYTE_W-1:0] wr_data;
  logic [BYTE_W-1:0] rd_addr;
  logic [BYTE_W-1:0] rd_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and produces registered edge/START/STOP strobes.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] scl_sync_q;
  logic [STAGES-1:0] sda_sync_q;
  logic              scl_hist_q;
  logic              sda_hist_q;
  logic              scl_s;
  logic              sda_s;

  assign scl_s = scl_sync_q[STAGES-1];
  assign sda_s = sda_sync_q[STAGES-1];

  // Flops reset to the idle-bus level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      sda_o      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[STAGES-2:0], sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
      scl_rise_o <= scl_s & ~scl_hist_q;
      scl_fall_o <= ~scl_s & scl_hist_q;
      start_o    <= scl_s & scl_hist_q & sda_hist_q & ~sda_s;
      stop_o     <= scl_s & scl_hist_q & ~sda_hist_q & sda_s;
      sda_o      <= sda_s;
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target bridging bus transfers to a byte-wide register port:
// pointer byte first, then auto-incrementing data bytes.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR    = 7'h0E,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe,
  output logic                      busy,
  i2c_target_regs_if.master         reg_if
);

  logic scl_rise;
  logic scl_fall;
  logic bus_start;
  logic bus_stop;
  logic sda_s;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop),
    .sda_o      (sda_s)
  );

  i2c_state_e           state_q,    state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [BYTE_W-1:0]    shift_q,    shift_d;
  logic [BYTE_W-1:0]    ptr_q,      ptr_d;
  logic                 ptr_inc_q,  ptr_inc_d;
  logic                 rw_q,       rw_d;
  logic                 acked_q,    acked_d;
  logic                 sda_oe_q,   sda_oe_d;
  logic                 busy_q,     busy_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [BYTE_W-1:0]    wr_addr_q,  wr_addr_d;
  logic [BYTE_W-1:0]    wr_data_q,  wr_data_d;
  logic [BYTE_W-1:0]    rx_byte;

  assign rx_byte = {shift_q[BYTE_W-2:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      ptr_inc_q  <= 1'b0;
      rw_q       <= I2C_RW_WRITE;
      acked_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      ptr_inc_q  <= ptr_inc_d;
      rw_q       <= rw_d;
      acked_q    <= acked_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // In the *_ACK receive states sda_oe_q doubles as the phase bit:
  // first fall starts the ACK, second fall ends it.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    ptr_inc_d  = 1'b0;
    rw_d       = rw_q;
    acked_d    = acked_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (ptr_inc_q) begin
      ptr_d = ptr_q + BYTE_W'(1);
    end

    if (bus_stop) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      acked_d  = 1'b0;
    end else if (bus_start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      acked_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              if (rx_byte[BYTE_W-1:1] == DEV_ADDR) begin
                rw_d    = rx_byte[0];
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q == I2C_RW_READ) begin
              shift_d   = reg_if.rd_data;
              sda_oe_d  = ~reg_if.rd_data[BYTE_W-1];
              bit_cnt_d = '0;
              state_d   = ST_RDATA;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_PTR;
            end
          end
        end

        ST_PTR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              ptr_d   = rx_byte;
              state_d = ST_PTR_ACK;
            end
          end
        end

        ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = rx_byte;
              ptr_inc_d  = 1'b1;
              state_d    = ST_WDATA_ACK;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_WDATA;
            end
          end
        end

        // Each fall shifts out the next bit; the MSB was driven on entry.
        ST_RDATA: begin
          if (scl_fall) begin
            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
            sda_oe_d = ~shift_q[BYTE_W-2];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_RDATA_ACK;
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_fall) begin
            if (acked_q) begin
              shift_d   = reg_if.rd_data;
              sda_oe_d  = ~reg_if.rd_data[BYTE_W-1];
              bit_cnt_d = '0;
              acked_d   = 1'b0;
              state_d   = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
            end
          end else if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              ptr_inc_d = 1'b1;
              acked_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign sda_oe          = sda_oe_q;
  assign busy            = busy_q;
  assign reg_if.wr_valid = wr_valid_q;
  assign reg_if.wr_addr  = wr_addr_q;
  assign reg_if.wr_data  = wr_data_q;
  assign reg_if.rd_addr  = ptr_q;

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- Synthesizable I2C target (responder) for the I2C master's bus. Oversamples SCL/SDA on the system clock and answers to one 7-bit address.
- Bridges bus transfers to a byte-wide register port on the host side: pointer byte first, then data bytes with auto-increment.
- Drives SDA open-drain only (pull low or release). Never drives SCL; no clock stretching.

Parameters:
- DEV_ADDR, 7'h0E, 7-bit target address this block ACKs.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2).

Ports:
- clk  in  1  system clock; period ≤ 1/8 of the SCL period.
- rst_n  in  1  asynchronous, active-low reset.
- scl_i  in  1  bus SCL level, asynchronous.
- sda_i  in  1  bus SDA level, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- wr_valid  out  1  one-clk pulse per written data byte.
- wr_addr  out  8  register address for wr_valid.
- wr_data  out  8  data for wr_valid.
- rd_addr  out  8  current pointer; host presents rd_data for it.
- rd_data  in  8  register contents at rd_addr; combinational from host.
- busy  out  1  high from START to STOP.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_addr(pointer)=0, busy=0, state=IDLE.
- Synchronizers and edges: scl_i and sda_i pass through SYNC_STAGES flops, plus one history flop each for edge detect.
  - scl_rise / scl_fall: single-clk strobes.
  - START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- Bit sampling and driving:
  - SDA is sampled on scl_rise. All bits are MSB first.
  - sda_oe changes only on scl_fall, except that START, STOP and reset release it at once.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START from any state, including a repeated START: bit counter cleared, go to ADDR, busy=1. The pointer is kept.
- STOP from any state: go to IDLE, sda_oe=0, busy=0.
- ADDR: shift in 8 bits (7 address bits + R/W).
  - After the 8th rise: if the address equals DEV_ADDR, assert sda_oe on the next scl_fall and go to ADDR_ACK. Otherwise go to IDLE with SDA released (NACK) and ignore the bus until the next START.
- ADDR_ACK: release on the scl_fall that ends the ACK bit.
  - R/W=0: go to PTR.
  - R/W=1: latch rd_data into the shift register on that same fall, drive its MSB, go to RDATA.
- PTR: 8 bits become the pointer; ACK in PTR_ACK; then WDATA.
- WDATA: 8 bits received, then ACK in WDATA_ACK.
  - At the 8th scl_rise: wr_valid pulses for one clk with wr_addr = pointer and wr_data = byte.
  - The pointer increments in the next clk, wrapping 8'hFF→8'h00.
  - Further bytes repeat WDATA.
- RDATA: on each scl_fall, sda_oe = ~shift_bit (a 0 bit pulls low). After 8 bits, release SDA for the master's ACK bit (RDATA_ACK).
- RDATA_ACK: sample the master's bit on scl_rise.
  - Master ACK (0): pointer increments (wrap). On the following scl_fall, latch rd_data for the new pointer and continue RDATA.
  - Master NACK (1): keep SDA released and go to IDLE to wait for STOP/START. busy stays 1 until STOP.
- rd_data timing: sampled on the clk of the latching scl_fall. rd_addr has then been stable for at least half an SCL period.
- Reset mid-transfer: everything returns to reset values immediately, SDA released, no wr_valid. The next transaction needs a fresh START.
- A START or STOP inside a byte aborts it. A partial WDATA byte produces no wr_valid.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum;
  - the constants I2C_RW_WRITE=0, I2C_RW_READ=1 and I2C_ACK=0, I2C_NACK=1;
  - the bit-count width (3 bits).
- One sub-module i2c_bus_sync: synchronizers for SCL and SDA, plus scl_rise/scl_fall/start/stop strobes. Instantiated once.

Test Plan:
- Single write: START, 0x1C (addr 0x0E + W), 0x03, 0xA5, STOP → ACK on all three bytes; exactly one wr_valid with wr_addr=0x03, wr_data=0xA5; busy drops after STOP.
- Burst write with wrap: START, 0x1C, 0xFF, 0x11, 0x22, STOP → wr_valid (0xFF,0x11) then (0x00,0x22).
- Write pointer then repeated-START read: START, 0x1C, 0x05, Sr, 0x1D, host rd_data=0x2A for addr 5 and 0x3C for addr 6, master ACK then NACK, STOP → SDA shows 0x2A then 0x3C; rd_addr ends at 0x06; no wr_valid.
- Address mismatch: START, 0x22, 0x55, STOP → SDA never pulled low (NACK); no wr_valid; pointer unchanged.
- Reset mid-byte: assert rst_n=0 after 4 bits of a data byte → sda_oe=0 and busy=0 at once; no wr_valid; next valid write transaction succeeds.
- STOP mid-byte: START, 0x1C, 0x07, 4 bits, STOP → no wr_valid; state IDLE; busy=0.
